// File: rtl/iter_arith_resp_pkg.sv
// Shared encodings for the En/Fim arithmetic responder and its control FSM.
// Holds the operation codes and the responder state encoding.
package iter_arith_resp_pkg;

  localparam int W_DEF  = 16;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

endpackage

// File: rtl/iter_arith_resp_add_sub.sv
// Combinational W-bit adder/subtractor shared by every operation.
// co_o is the carry out when adding and the borrow (x < y) when subtracting.
module add_sub_w #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic [W:0] ext;

  always_comb begin
    if (sub_i) ext = {1'b0, x_i} - {1'b0, y_i};
    else       ext = {1'b0, x_i} + {1'b0, y_i};
  end

  assign s_o  = ext[W-1:0];
  assign co_o = ext[W];

endmodule

// File: rtl/iter_arith_resp.sv
// Iterative add/sub/mul/div responder for the En/Fim handshake.
// Operands are latched on accept; fim pulses once with result/resto held stable.
module iter_arith_resp
  import iter_arith_resp_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         fim,
  output logic [W-1:0] result,
  output logic [W-1:0] resto,
  output logic         menor,
  output logic         div_zero,
  output logic         ovf,
  output state_e       dbg_state
);

  // Handshake: en is a level request sampled only in IDLE; the block answers
  // with a single fim pulse and then waits in HOLD until en is seen low, so an
  // en held high can never start a second operation.

  state_e         state_q;
  op_e            op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   acc_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, fim_q;
  logic [W-1:0]   result_q, resto_q;
  logic           menor_q, div_zero_q, ovf_q;

  logic [W-1:0]   as_x, as_y, as_s;
  logic           as_sub, as_co;
  logic [CW-1:0]  cnt_inc;

  // acc_q holds the running product for mul and the running remainder for div.
  always_comb begin
    as_x   = a_q;
    as_y   = b_q;
    as_sub = 1'b0;
    case (op_q)
      OP_SUB: as_sub = 1'b1;
      OP_MUL: begin
        as_x = acc_q;
        as_y = a_q;
      end
      OP_DIV: begin
        as_x   = acc_q;
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  add_sub_w #(.W(W)) u_add_sub (
    .x_i   (as_x),
    .y_i   (as_y),
    .sub_i (as_sub),
    .s_o   (as_s),
    .co_o  (as_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      fim_q      <= 1'b0;
      result_q   <= '0;
      resto_q    <= '0;
      menor_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fim_q <= 1'b0;
          if (en) begin
            op_q       <= op_e'(op);
            a_q        <= a;
            b_q        <= b;
            result_q   <= '0;
            resto_q    <= '0;
            menor_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            if (op_e'(op) == OP_MUL) begin
              acc_q <= '0;
              cnt_q <= b[CW-1:0];
            end else begin
              acc_q <= a;
              cnt_q <= '0;
            end
            state_q <= ST_CALC;
          end
        end

        ST_CALC: begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              result_q <= as_s;
              ovf_q    <= as_co;
              state_q  <= ST_DONE;
            end
            OP_MUL: begin
              if (cnt_q == '0) begin
                result_q <= '0;
                state_q  <= ST_DONE;
              end else begin
                acc_q <= as_s;
                ovf_q <= ovf_q | as_co;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                  result_q <= as_s;
                  state_q  <= ST_DONE;
                end
              end
            end
            default: begin
              // Borrow on rem - b can only occur on the first step (a < b).
              if (b_q == '0) begin
                div_zero_q <= 1'b1;
                resto_q    <= acc_q;
                state_q    <= ST_DONE;
              end else if (as_co) begin
                menor_q <= 1'b1;
                resto_q <= acc_q;
                state_q <= ST_DONE;
              end else begin
                acc_q <= as_s;
                cnt_q <= cnt_inc;
                if (as_s < b_q) begin
                  result_q <= W'(cnt_inc);
                  resto_q  <= as_s;
                  state_q  <= ST_DONE;
                end else if (cnt_inc == '1) begin
                  ovf_q    <= 1'b1;
                  result_q <= W'(cnt_inc);
                  resto_q  <= as_s;
                  state_q  <= ST_DONE;
                end
              end
            end
          endcase
        end

        ST_DONE: begin
          fim_q   <= 1'b1;
          state_q <= ST_HOLD;
        end

        default: begin
          fim_q  <= 1'b0;
          busy_q <= 1'b0;
          if (!en) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign fim       = fim_q;
  assign result    = result_q;
  assign resto     = resto_q;
  assign menor     = menor_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iter_arith_resp.sv
// Self-checking bench for iter_arith_resp: directed handshake/boundary cases
// plus randomized operations checked against an arithmetic reference model.
module tb_iter_arith_resp;
  import iter_arith_resp_pkg::*;

  localparam int W  = 16;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, fim, menor, div_zero, ovf;
  logic [W-1:0] result, resto;
  state_e       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  iter_arith_resp #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .fim       (fim),
    .result    (result),
    .resto     (resto),
    .menor     (menor),
    .div_zero  (div_zero),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached (%0d checks, %0d failures)", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: straight arithmetic on the operation definitions.
  task automatic ref_model(input logic [1:0] o, input int unsigned xa, input int unsigned xb,
                           output int unsigned r, output int unsigned rs,
                           output bit mn, output bit dz, output bit ov, output int n);
    int unsigned m, p, q;
    r = 0; rs = 0; mn = 0; dz = 0; ov = 0; n = 1;
    case (o)
      2'b00: begin
        p  = xa + xb;
        r  = p % 65536;
        ov = (p > 65535);
      end
      2'b01: begin
        r  = (xa - xb) & 32'hFFFF;
        ov = (xa < xb);
      end
      2'b10: begin
        m  = xb % 256;
        p  = xa * m;
        r  = p & 32'hFFFF;
        ov = (p > 65535);
        n  = (m == 0) ? 1 : int'(m);
      end
      default: begin
        if (xb == 0) begin
          rs = xa; dz = 1;
        end else if (xa < xb) begin
          rs = xa; mn = 1;
        end else begin
          q = xa / xb;
          if (q > 255) begin
            r = 255; rs = xa - 255 * xb; ov = 1; n = 255;
          end else begin
            r = q; rs = xa % xb; n = int'(q);
          end
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at #1 after a posedge with the DUT in IDLE; returns the same way.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input int hold, input bit drop, input bit scramble, input string tag);
    int unsigned r, rs;
    bit mn, dz, ov;
    int n, lat, extra;
    bit got, busy_ok;
    logic [W-1:0] exp_r;
    ref_model(o, xa, xb, r, rs, mn, dz, ov, n);
    exp_q.push_back(r[W-1:0]);
    en = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    check({tag, "_busy_accept"}, busy, 1);
    lat = 0; got = 0; busy_ok = 1;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (fim) got = 1;
      if (!busy) busy_ok = 0;
      if (!got && lat == 1) begin
        if (scramble) begin
          op = ~o; a = W'($urandom); b = W'($urandom);
        end
        if (drop) en = 1'b0;
      end
    end
    exp_r = exp_q.pop_front();
    if (!got) begin
      check({tag, "_fim_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, lat, n + 1);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_resto"}, resto, rs);
      check({tag, "_menor"}, menor, mn);
      check({tag, "_div_zero"}, div_zero, dz);
      check({tag, "_ovf"}, ovf, ov);
      check({tag, "_busy_span"}, busy_ok, 1);
      extra = 0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (fim) extra++;
      end
      en = 1'b0;
      @(posedge clk); #1;
      if (fim) extra++;
      check({tag, "_extra_fim"}, extra, 0);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_result_held"}, result, exp_r);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int abort_fims;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; en = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fim", fim, 0);
    check("rst_result", result, 0);
    check("rst_resto", resto, 0);
    check("rst_flags", {menor, div_zero, ovf}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic and boundary cases
    do_op(OP_ADD, 16'h0012, 16'h0034, 0, 0, 0, "add");
    do_op(OP_SUB, 16'd5, 16'd9, 0, 0, 0, "sub_borrow");
    do_op(OP_MUL, 16'd7, 16'd0, 0, 0, 0, "mul_zero");
    do_op(OP_MUL, 16'h0100, 16'h00FF, 0, 0, 0, "mul_255");
    do_op(OP_MUL, 16'hFFFF, 16'd3, 0, 0, 0, "mul_ovf");
    do_op(OP_DIV, 16'd100, 16'd7, 0, 0, 0, "div");
    do_op(OP_DIV, 16'd3, 16'd9, 0, 0, 0, "div_menor");
    do_op(OP_DIV, 16'd0, 16'd4, 0, 0, 0, "div_a0");
    do_op(OP_DIV, 16'd5, 16'd0, 0, 0, 0, "div_zero");
    do_op(OP_DIV, 16'hFFFF, 16'd2, 0, 0, 0, "div_qcap");
    do_op(OP_ADD, 16'hFFFF, 16'h0002, 0, 0, 0, "add_carry");

    // Handshake behaviour
    do_op(OP_ADD, 16'h1111, 16'h2222, 20, 0, 0, "hold_en");
    do_op(OP_MUL, 16'h0100, 16'h00FF, 0, 0, 1, "scramble");
    do_op(OP_DIV, 16'd100, 16'd7, 0, 1, 0, "drop_en");

    // Reset during mul CALC aborts without a fim
    abort_fims = 0;
    en = 1'b1; op = OP_MUL; a = 16'd3; b = 16'd200;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (fim) abort_fims++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_fim", fim, 0);
    check("abort_result", result, 0);
    check("abort_resto", resto, 0);
    check("abort_flags", {menor, div_zero, ovf}, 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (fim) abort_fims++;
    end
    check("abort_no_fim", abort_fims, 0);
    do_op(OP_ADD, 16'd1, 16'd1, 0, 0, 0, "post_reset_add");

    // Back-to-back with en low for one cycle between requests
    do_op(OP_ADD, 16'h8000, 16'h8001, 0, 0, 0, "b2b_add");
    do_op(OP_SUB, 16'h1234, 16'h0234, 0, 0, 0, "b2b_sub");
    do_op(OP_MUL, 16'd300, 16'd12, 0, 0, 0, "b2b_mul");
    do_op(OP_DIV, 16'd1000, 16'd33, 0, 0, 0, "b2b_div");

    // Randomized operations
    repeat (40) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom);
        1:       rb = W'($urandom_range(0, 15));
        2:       rb = ra >> $urandom_range(1, 9);
        default: rb = W'($urandom_range(0, 300));
      endcase
      do_op(ro, ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
